// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter that lets Nreq requesters write
// bursts of up to MaxBurst words into a single FIFO write port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick the next requester after Ptr in round-robin order
// BURST | one requester granted; each accepted word is an Ack / FIFO write
//
// Ack is also held low while Rst is high. A burst aborted by reset then
// accepts no word in the reset cycle, and the requester and the FIFO stay in
// step: each requester advances its data on Ack, and the FIFO writes on nWr.
module fifo_wr_arbiter #(
    parameter int Bsize    = 8,
    parameter int Nreq     = 4,
    parameter int MaxBurst = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [Nreq-1:0]         Req,
    input  logic [Nreq*Bsize-1:0]   Din_Bus,
    output logic [Nreq-1:0]         Gnt,
    output logic [Nreq-1:0]         Ack,
    input  logic                    Full,
    output logic                    nWr,
    output logic [Bsize-1:0]        Dout,
    output logic                    Busy
);

    localparam int PW = (Nreq > 1) ? $clog2(Nreq) : 1;
    localparam int CW = $clog2(MaxBurst) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [CW-1:0] cnt;

    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;
    logic          sel_found;
    logic          any_ack;
    logic          req_g;
    logic          burst_end;

    assign Ack       = Rst ? '0 : (Gnt & Req & {Nreq{~Full}});
    assign any_ack   = |Ack;
    assign nWr       = ~any_ack;
    assign Busy      = (state == BURST);
    assign req_g     = Req[gidx];
    assign burst_end = ~req_g | (any_ack & (cnt == CW'(MaxBurst - 1)));

    // Round-robin search starting just after the last-served requester;
    // walking k downwards lets the nearest candidate overwrite farther ones.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = Nreq; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % Nreq);
            if (Req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Route the granted requester's word to the FIFO, zero when nothing is granted.
    always_comb begin
        Dout = '0;
        if (|Gnt) begin
            Dout = Din_Bus[int'(gidx)*Bsize +: Bsize];
        end
    end

    // Grant/burst sequencing, last-served pointer and burst word counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Gnt   <= '0;
            cnt   <= '0;
            ptr   <= PW'(Nreq - 1);
            gidx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        Gnt   <= {{(Nreq-1){1'b0}}, 1'b1} << sel_idx;
                        gidx  <= sel_idx;
                        cnt   <= '0;
                        state <= BURST;
                    end else begin
                        Gnt <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state <= IDLE;
                        Gnt   <= '0;
                        ptr   <= gidx;
                        cnt   <= '0;
                    end else if (any_ack) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations,
// a transaction-level round-robin model compared every cycle, and a random
// phase through a small FIFO model with a per-requester order scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int BS    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [NR-1:0]    Req = '0;
    logic [NR*BS-1:0] Din_Bus = '0;
    logic [NR-1:0]    Gnt;
    logic [NR-1:0]    Ack;
    logic             Full = 1'b0;
    logic             nWr;
    logic [BS-1:0]    Dout;
    logic             Busy;

    always #5 Clk = ~Clk;

    fifo_wr_arbiter #(.Bsize(BS), .Nreq(NR), .MaxBurst(MB)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Din_Bus(Din_Bus), .Gnt(Gnt),
        .Ack(Ack), .Full(Full), .nWr(nWr), .Dout(Dout), .Busy(Busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_words = 0;
    bit m_acc;

    function automatic int rr_pick(input int last, input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            m_owner = -1; m_last = NR - 1; m_words = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_pick(m_last, Req);
            m_words = 0;
        end else begin
            m_acc = Req[m_owner] && !Full;
            if (m_acc) m_words++;
            if ((m_acc && m_words == MB) || !Req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    end

    bit            cmp_en = 0;
    logic [NR-1:0] e_gnt, e_ack;
    logic [BS-1:0] e_dout;

    always @(negedge Clk) begin
        if (cmp_en) begin
            e_gnt  = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
            e_ack  = Rst ? '0 : (e_gnt & Req & {NR{!Full}});
            e_dout = '0;
            if (m_owner >= 0) e_dout = Din_Bus[m_owner*BS +: BS];
            chk("model_gnt",  32'(Gnt),  32'(e_gnt));
            chk("model_ack",  32'(Ack),  32'(e_ack));
            chk("model_nwr",  32'(nWr),  32'(e_ack == '0));
            chk("model_dout", 32'(Dout), 32'(e_dout));
            chk("model_busy", 32'(Busy), 32'(m_owner >= 0));
        end
    end

    // ---------------- requesters and FIFO ----------------
    int            seq[NR];
    int            rd_seq[NR];
    logic [NR-1:0] ackd = '0;
    bit            pend_wr = 0;
    logic [BS-1:0] pend_data = '0;
    logic [BS-1:0] fifo[$];
    bit            rnd_mode = 0;
    bit            draining = 0;

    always @(negedge Clk) begin
        for (int i = 0; i < NR; i++) begin
            ackd[i] = (Ack[i] === 1'b1);
            if (Ack[i] === 1'b1) seq[i] = seq[i] + 1;
        end
        pend_wr   = (nWr === 1'b0);
        pend_data = Dout;
    end

    task automatic cyc();
        logic [BS-1:0] w;
        int id;
        @(posedge Clk);
        #1;
        for (int i = 0; i < NR; i++) Din_Bus[i*BS +: BS] = {2'(i), 6'(seq[i])};
        if (rnd_mode) begin
            if (pend_wr) fifo.push_back(pend_data);
            if ($urandom_range(1) == 0 && fifo.size() > 0) begin
                w  = fifo.pop_front();
                id = int'(w[7:6]);
                chk("sb_order", 32'(w[5:0]), 32'(rd_seq[id] % 64));
                rd_seq[id] = rd_seq[id] + 1;
            end
            for (int i = 0; i < NR; i++) begin
                if (!Req[i]) begin
                    if (!draining && $urandom_range(2) == 0) Req[i] = 1'b1;
                end else if (ackd[i]) begin
                    if (draining || $urandom_range(3) == 0) Req[i] = 1'b0;
                end
            end
            Full = (fifo.size() >= DEPTH);
        end
    endtask

    task automatic reset_dut();
        cyc(); Rst = 1'b1; Req = '0; Full = 1'b0;
        cyc();
        cyc(); Rst = 1'b0;
    endtask

    int order[$];
    int wcnt[$];
    logic [NR-1:0] prevg;
    int n;
    bit done;

    initial begin
        for (int i = 0; i < NR; i++) begin seq[i] = 0; rd_seq[i] = 0; end

        // reset state and single requester bursts
        reset_dut();
        cmp_en = 1;
        Req = 4'b0001;
        @(negedge Clk);
        chk("rst_gnt",  32'(Gnt),  0);
        chk("rst_nwr",  32'(nWr),  1);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_busy", 32'(Busy), 0);
        cyc(); @(negedge Clk);
        chk("r30_gnt", 32'(Gnt), 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin cyc(); @(negedge Clk); end
            chk("r30_ack", 32'(Ack), 1);
            chk("r30_nwr", 32'(nWr), 0);
        end
        cyc(); @(negedge Clk);
        chk("r30_gap_gnt", 32'(Gnt), 0);
        chk("r30_gap_nwr", 32'(nWr), 1);
        cyc(); @(negedge Clk);
        chk("r30_regrant", 32'(Gnt), 1);

        // all requesting: round-robin order with full bursts
        reset_dut();
        Req = 4'b1111;
        prevg = '0;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) cyc();
            @(negedge Clk);
            if (Gnt != '0 && prevg == '0) begin
                order.push_back(oh2i(Gnt));
                wcnt.push_back(0);
            end
            if (Ack != '0 && wcnt.size() > 0) begin
                wcnt[wcnt.size()-1] = wcnt[wcnt.size()-1] + 1;
                chk("r31_dout", 32'(Dout), 32'(Din_Bus[oh2i(Gnt)*BS +: BS]));
            end
            prevg = Gnt;
        end
        chk("r31_ngrants", 32'(order.size()), 5);
        for (int i = 0; i < order.size() && i < 5; i++) begin
            chk("r31_order",  32'(order[i]), 32'(i % 4));
            chk("r31_writes", 32'(wcnt[i]),  4);
        end
        Req = '0;

        // early drop by requester 2, then round-robin continues at 3
        reset_dut();
        Req = 4'b0100;
        @(negedge Clk);
        cyc(); @(negedge Clk);
        chk("r32_gnt",  32'(Gnt), 4);
        chk("r32_ack1", 32'(Ack), 4);
        cyc(); @(negedge Clk);
        chk("r32_ack2", 32'(Ack), 4);
        cyc(); Req = 4'b1001; @(negedge Clk);
        chk("r32_drop_gnt", 32'(Gnt), 4);
        chk("r32_drop_ack", 32'(Ack), 0);
        cyc(); @(negedge Clk);
        chk("r32_idle_gnt",  32'(Gnt),  0);
        chk("r32_idle_busy", 32'(Busy), 0);
        cyc(); @(negedge Clk);
        chk("r32_next_gnt", 32'(Gnt), 8);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin cyc(); @(negedge Clk); end
            if (Ack == 4'b1000) n++;
        end
        chk("r32_full_burst", 32'(n), 4);
        Req = '0;

        // Full stall mid-burst
        reset_dut();
        Req = 4'b0001;
        @(negedge Clk);
        cyc(); @(negedge Clk);
        chk("r33_ack1", 32'(Ack), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(); Full = 1'b1; @(negedge Clk);
            chk("r33_stall_nwr", 32'(nWr), 1);
            chk("r33_stall_gnt", 32'(Gnt), 1);
        end
        n = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(); Full = 1'b0; @(negedge Clk);
            if (Ack == 4'b0001) n++;
        end
        chk("r33_resume", 32'(n), 3);
        cyc(); @(negedge Clk);
        chk("r33_end_gnt", 32'(Gnt), 0);
        Req = '0;

        // reset in the middle of a burst
        reset_dut();
        Req = 4'b0010;
        @(negedge Clk);
        cyc(); @(negedge Clk);
        chk("r34_ack1", 32'(Ack), 2);
        cyc(); @(negedge Clk);
        chk("r34_ack2", 32'(Ack), 2);
        cyc(); Rst = 1'b1; @(negedge Clk);
        chk("r34_rst_ack", 32'(Ack), 0);
        chk("r34_rst_nwr", 32'(nWr), 1);
        cyc(); Rst = 1'b0; Req = 4'b1111; @(negedge Clk);
        chk("r34_gnt",  32'(Gnt),  0);
        chk("r34_busy", 32'(Busy), 0);
        chk("r34_ack",  32'(Ack),  0);
        cyc(); @(negedge Clk);
        chk("r34_first", 32'(Gnt), 1);

        // random traffic through a FIFO model with scoreboard
        reset_dut();
        Req = '0;
        fifo.delete();
        for (int i = 0; i < NR; i++) rd_seq[i] = seq[i];
        draining = 0;
        rnd_mode = 1;
        repeat (3000) cyc();
        draining = 1;
        done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            cyc();
            if (Req == '0 && fifo.size() == 0 && !pend_wr) done = 1;
        end
        chk("drain_timeout", 32'(done), 1);
        for (int i = 0; i < NR; i++) chk("sb_loss", 32'(rd_seq[i]), 32'(seq[i]));
        rnd_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter Bsize, default 8, data word width in bits.
REQ-002 The block SHALL have parameter Nreq, default 4, number of requesters (2..8).
REQ-003 The block SHALL have parameter MaxBurst, default 4, maximum words written per grant (1..16).
REQ-004 The block SHALL have port Clk, input, 1, single clock; all logic on posedge.
REQ-005 The block SHALL have port Rst, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port Req, input, Nreq, per-requester "data valid" level.
REQ-007 The block SHALL have port Din_Bus, input, Nreq*Bsize, requester i data on bits [i*Bsize+Bsize-1 : i*Bsize].
REQ-008 The block SHALL have port Gnt, output, Nreq, registered one-hot grant; all-zero when no grant.
REQ-009 The block SHALL have port Ack, output, Nreq, combinational per-word accept strobe.
REQ-010 The block SHALL have port Full, input, 1, FIFO full flag, write-clock domain.
REQ-011 The block SHALL have port nWr, output, 1, active-low FIFO write strobe.
REQ-012 The block SHALL have port Dout, output, Bsize, data to FIFO Din.
REQ-013 The block SHALL have port Busy, output, 1, high while state is BURST.

Function
REQ-014 The block SHALL implement two states, IDLE and BURST, plus a registered last-served pointer Ptr (clog2(Nreq) bits) and a burst counter Cnt (clog2(MaxBurst)+1 bits).
REQ-015 In IDLE with Req != 0, the block SHALL select the first asserted Req searching Ptr+1, Ptr+2, ... modulo Nreq, register one-hot Gnt, clear Cnt to 0, and enter BURST on the next edge.
REQ-016 In IDLE with Req == 0, the block SHALL keep Gnt = 0 and remain in IDLE.
REQ-017 Ack[i] SHALL equal Gnt[i] & Req[i] & ~Full; nWr SHALL equal ~|Ack.
REQ-018 Dout SHALL carry the granted requester's Din_Bus slice while Gnt != 0, else all zeros.
REQ-019 Each cycle with an Ack SHALL increment Cnt by 1.
REQ-020 In BURST, the block SHALL return to IDLE, clear Gnt and set Ptr to the granted index on the next edge when either an Ack occurs with Cnt == MaxBurst-1, or Req[granted] is 0.
REQ-021 In BURST with Full = 1 and Req[granted] = 1, the block SHALL hold state, Gnt and Cnt unchanged with nWr = 1, and SHALL impose no timeout.
REQ-022 Grant latency SHALL be one cycle: a Req sampled in IDLE at edge N gives Gnt at N+1, and the first possible Ack is in cycle N+1.
REQ-023 Between consecutive grants there SHALL be exactly one IDLE cycle with Gnt = 0 and nWr = 1.
REQ-024 Simultaneous requests SHALL be resolved only by the round-robin order of REQ-015; a requester SHALL NOT be granted twice in succession while any other Req is high at the IDLE decision.
REQ-025 Requesters SHALL hold Din_Bus stable and Req high until Ack; Req may drop only after an Ack. Behaviour on a violation is undefined, except that REQ-020 still applies.
REQ-026 Write gating SHALL use the same Full the FIFO uses, so every Ack corresponds to exactly one FIFO write.

Reset
REQ-027 While Rst = 1 at a posedge, the block SHALL set state = IDLE, Gnt = 0, Cnt = 0 and Ptr = Nreq-1, so requester 0 has first priority after reset.
REQ-028 With state = IDLE and Gnt = 0, the block SHALL drive Ack = 0, nWr = 1, Dout = 0 and Busy = 0.
REQ-029 Reset asserted during BURST SHALL abort the burst at that edge with no further Ack, and no partial-burst state SHALL persist.

Verification (Nreq = 4, MaxBurst = 4, Bsize = 8)
REQ-030 A bench SHALL apply reset, then Req = 4'b0001 held with Full = 0, and check Gnt = 0001 one cycle later, 4 consecutive Acks with nWr = 0, one IDLE gap, then a regrant to requester 0.
REQ-031 A bench SHALL apply Req = 4'b1111 continuously with Full = 0, and check grant order 0, 1, 2, 3, 0, with 4 writes each and Dout matching each slice.
REQ-032 A bench SHALL grant requester 2 and drop Req[2] after 2 Acks, and check return to IDLE with Cnt reset, Ptr = 2, and the next grant going to 3 when Req = 4'b1001.
REQ-033 A bench SHALL raise Full for 5 cycles mid-burst after 1 Ack, and check nWr = 1 and Gnt stable during the stall, then the remaining 3 Acks after Full falls (4 total).
REQ-034 A bench SHALL assert Rst in the cycle after the 2nd Ack of a burst, and check no further Ack, Gnt = 0, Busy = 0, and that a following Req = 4'b1111 grants requester 0 first.
REQ-035 A bench SHALL connect the block to the FIFO with a common clock and random Req/Full, and a scoreboard SHALL check per-requester order, zero loss and zero duplication.
